uart_rx_oversampled: RTL
========================

// Module: uart_rx_oversampled
// PURPOSE
//  UART 8N1-style receiver that consumes the oversampled clock produced by baud_generator.
//  Detects start bits, majority-votes each bit at its centre and deserialises LSB-first.
//  Presents each received byte on a valid/ready holding register to the downstream consumer.
//  Flags framing errors and overruns.
// PARAMETERS
//  OVERSAMPLING  8  ticks per bit; must be even and >=4 (match the baud_generator setting)
//  DATA_BITS     8  data bits per frame; 5..9
// PORTS
//  clk_in          input   1          system clock; same clock as baud_generator
//  rst_in          input   1          asynchronous reset, active-high
//  baud_tick_in    input   1          baud_generator clk_out (toggling, clk_in domain)
//  rx_in           input   1          serial line, asynchronous, idle high
//  ready_in        input   1          consumer accepts data_out when high with valid_out
//  data_out        output  DATA_BITS  received byte; LSB = first data bit
//  valid_out       output  1          data_out holds an unconsumed byte
//  frame_err_out   output  1          1-cycle pulse: stop bit sampled 0
//  overrun_err_out output  1          1-cycle pulse: new byte dropped, holding register full
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters 0, rx sync flops 1, last_rx 1, baud_tick_q 0.
//  Reset applies immediately, including mid-frame; any partial frame is discarded.
//  Tick: tick = baud_tick_in & ~baud_tick_q (rising edge, one cycle long). FSM advances only on tick cycles.
//  rx_in passes through a 2-flop synchroniser, rx_s. last_rx = rx_s captured on the previous tick.
//  M = OVERSAMPLING/2. tick_cnt counts 0..OVERSAMPLING-1 within a bit.
//  Bit vote = majority of rx_s sampled at tick_cnt M-1, M, M+1.
//  IDLE: on tick with rx_s==0 && last_rx==1 -> START, tick_cnt=0.
//    A line held low (break) does not retrigger a start.
//  START: tick_cnt++. At tick_cnt==OVERSAMPLING-1:
//    vote==1 (false start) -> IDLE.
//    vote==0 -> DATA, tick_cnt=0, bit_cnt=0.
//  DATA: vote is shifted in MSB-side and the shift register shifts right (LSB-first).
//    At tick_cnt==OVERSAMPLING-1: bit_cnt++, tick_cnt=0.
//    After DATA_BITS bits -> STOP.
//  STOP: on the tick with tick_cnt==M+1, evaluate the vote and go to IDLE.
//    Early return allows half-bit resync.
//    vote==0: frame_err_out pulses 1 cycle; byte is discarded.
//    vote==1: byte completes and goes to holding-register logic.
//  Holding register: valid_out is registered and rises on the clock edge of the completing tick.
//    Accept: valid_out && ready_in -> valid_out clears next edge unless a byte completes that same cycle.
//    Complete with (!valid_out || ready_in): data_out <= byte, valid_out <= 1.
//    Complete with valid_out && !ready_in: data_out unchanged, overrun_err_out pulses 1 cycle.
//  data_out is stable whenever valid_out==1 and is not accepted.
//  tick_cnt and bit_cnt never wrap outside their ranges. Ticks outside a frame are ignored except in IDLE.
// TESTING
//  (Bench: OVERSAMPLING=8; baud_tick_in toggles every 4 clk_in cycles, so 64 clk per bit.)
//  1. Send 0xA5, stop=1, ready_in=1 -> valid_out high 1 cycle, data_out=0xA5; no error pulses.
//  2. Send 0x3C with stop=0, then line high 2 bits, then 0x55
//     -> frame_err_out single pulse, no valid for 0x3C; then data_out=0x55 valid.
//  3. Idle line, low glitch of 2 ticks -> returns to IDLE, no valid, no error; next frame 0x81 received correctly.
//  4. ready_in=0, send 0x11 then 0x22
//     -> valid_out=1 with data_out=0x11, overrun_err_out pulse at 0x22 stop, data_out stays 0x11.
//     Then ready_in=1 for 1 cycle -> valid_out drops.
//  5. Send 0x6B with a 1-tick inverted glitch at tick M of bit 2 -> majority vote corrects; data_out=0x6B.
//  6. Assert rst_in asynchronously during data bit 3 -> outputs 0 without clock edge.
//     Release, send 0xF0 -> data_out=0xF0 valid, no errors.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
// Oversampled UART receiver. It finds the start bit on the synchronised line,
// takes a 3-sample majority vote at the centre of every bit and shifts the data
// in LSB-first. Each completed byte is offered on a valid/ready holding register.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_oversampled #(
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 baud_tick_in,
  input  logic                 rx_in,
  input  logic                 ready_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_err_out,
  output logic                 overrun_err_out
);

  localparam int M  = OVERSAMPLING / 2;
  localparam int TW = $clog2(OVERSAMPLING);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
  localparam logic [TW-1:0] TICK_S0   = TW'(M - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(M);
  localparam logic [TW-1:0] TICK_S2   = TW'(M + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_reg;
  logic                   baud_tick_q;
  logic                   rx_meta_reg;
  logic                   rx_s;
  logic                   last_rx;
  logic [TW-1:0]          tick_cnt_reg;
  logic [BW-1:0]          bit_cnt_reg;
  logic [2:0]             samp_reg;
  logic [DATA_BITS-1:0]   shift_reg;

  logic tick;
  logic vote_mid;
  logic vote_stop;
  logic stop_eval;
  logic byte_done;

  // One-cycle strobe on each rising edge of the toggling baud clock.
  assign tick = baud_tick_in & ~baud_tick_q;

  // Majority over the three centre samples; in the stop bit the third sample is
  // the live line value, because the decision is taken on that very tick.
  assign vote_mid  = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & samp_reg[2]) |
                     (samp_reg[1] & samp_reg[2]);
  assign vote_stop = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) |
                     (samp_reg[1] & rx_s);

  assign stop_eval = tick && (state_reg == STOP) && (tick_cnt_reg == TICK_S2);
  assign byte_done = stop_eval && vote_stop;

  // Baud edge detector, line synchroniser and the per-tick copy of the line.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      baud_tick_q <= 1'b0;
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
      last_rx     <= 1'b1;
    end else begin
      baud_tick_q <= baud_tick_in;
      rx_meta_reg <= rx_in;
      rx_s        <= rx_meta_reg;
      if (tick) begin
        last_rx <= rx_s;
      end
    end
  end

  // Frame FSM: start detection, centre sampling, deserialisation, stop check.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= IDLE;
      tick_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      samp_reg      <= '0;
      shift_reg     <= '0;
      frame_err_out <= 1'b0;
    end else begin
      frame_err_out <= 1'b0;
      if (tick) begin
        if (state_reg != IDLE) begin
          if (tick_cnt_reg == TICK_S0) samp_reg[0] <= rx_s;
          if (tick_cnt_reg == TICK_S1) samp_reg[1] <= rx_s;
          if (tick_cnt_reg == TICK_S2) samp_reg[2] <= rx_s;
        end
        case (state_reg)
          IDLE: begin
            // Only a high-to-low transition starts a frame, so a held break
            // line cannot retrigger.
            if (!rx_s && last_rx) begin
              state_reg    <= START;
              tick_cnt_reg <= '0;
            end
          end
          START: begin
            if (tick_cnt_reg == TICK_LAST) begin
              tick_cnt_reg <= '0;
              bit_cnt_reg  <= '0;
              state_reg    <= vote_mid ? IDLE : DATA;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt_reg == TICK_LAST) begin
              shift_reg    <= {vote_mid, shift_reg[DATA_BITS-1:1]};
              tick_cnt_reg <= '0;
              if (bit_cnt_reg == BIT_LAST) begin
                bit_cnt_reg <= '0;
                state_reg   <= STOP;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
          STOP: begin
            // Decide mid-stop-bit and leave early so the next start edge is
            // caught even when the transmitter runs slightly fast.
            if (tick_cnt_reg == TICK_S2) begin
              tick_cnt_reg  <= '0;
              state_reg     <= IDLE;
              frame_err_out <= ~vote_stop;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
          default: begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
          end
        endcase
      end
    end
  end

  // Holding register: load on completion if free or being drained this cycle,
  // otherwise drop the new byte and flag an overrun.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_out        <= '0;
      valid_out       <= 1'b0;
      overrun_err_out <= 1'b0;
    end else begin
      overrun_err_out <= 1'b0;
      if (byte_done) begin
        if (!valid_out || ready_in) begin
          data_out  <= shift_reg;
          valid_out <= 1'b1;
        end else begin
          overrun_err_out <= 1'b1;
        end
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
